// File: rtl/rr_selector_arbiter.sv
// Round-robin arbiter that owns the select code of a shared 4-to-1 data selector.
// Each grant is capped at MAX_HOLD cycles; the selected data bit is gated onto f.
module rr_selector_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       f
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] search_base;
    logic [3:0] rot_req;
    logic [1:0] win_off;
    logic [1:0] win_idx;
    logic       found;
    logic       release_grant;

    // On release the pointer moves past the current owner, so search starts there.
    assign search_base = (state_q == BUSY) ? sel_q + 2'd1 : ptr_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam logic [1:0] OFF = 2'(gi);
            assign rot_req[gi] = req[search_base + OFF];
        end
    endgenerate

    always_comb begin
        found   = |rot_req;
        win_off = 2'd0;
        if (rot_req[0])      win_off = 2'd0;
        else if (rot_req[1]) win_off = 2'd1;
        else if (rot_req[2]) win_off = 2'd2;
        else if (rot_req[3]) win_off = 2'd3;
        win_idx = search_base + win_off;
    end

    assign release_grant = !req[sel_q] || (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BUSY;
                    grant_d    = 4'b0001 << win_idx;
                    sel_d      = win_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = 4'd0;
                end
            end
            BUSY: begin
                if (!release_grant) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end else begin
                    ptr_d      = search_base;
                    hold_cnt_d = 4'd0;
                    if (found) begin
                        grant_d = 4'b0001 << win_idx;
                        sel_d   = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            sel_q      <= 2'b00;
            ptr_q      <= 2'b00;
            busy_q     <= 1'b0;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
    assign f     = busy_q & din[sel_q];

endmodule
